// File: rtl/fft_frame_sched_pkg.sv
// Shared constants and FSM state encoding for the FFT frame scheduler.
package fft_sched_pkg;

    localparam int DATA_WIDTH_DEF   = 16;
    localparam int FFT_STAGE_DEF    = 6;
    localparam int MAX_INFLIGHT_DEF = 2;
    localparam int FFT_MAX          = 1 << FFT_STAGE_DEF;
    localparam int CNT_W            = FFT_STAGE_DEF;
    localparam int INFL_W           = 3;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

endpackage

// File: rtl/fft_frame_sched_if.sv
// Sample-stream, core-side and status signals of the FFT frame scheduler.
// s_valid/s_ready: a sample moves on every rising clk edge where both are high; s_valid may drop freely.
interface fft_frame_sched_if #(
    parameter int DW = 16
);
    import fft_sched_pkg::*;

    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_real;
    logic [DW-1:0] s_imag;
    logic          core_en;
    logic [DW-1:0] core_real;
    logic [DW-1:0] core_imag;
    logic          core_oen;
    logic          m_last;
    logic          busy;
    logic [15:0]   frames_out;
    logic          err;
    state_t        dbg_state;

    modport slave (
        input  s_valid, s_real, s_imag, core_oen,
        output s_ready, core_en, core_real, core_imag, m_last, busy, frames_out, err, dbg_state
    );

    modport master (
        output s_valid, s_real, s_imag, core_oen,
        input  s_ready, core_en, core_real, core_imag, m_last, busy, frames_out, err, dbg_state
    );

endinterface

// File: rtl/fft_frame_sched_ram.sv
// Simple dual-port frame buffer with a registered read port; the array itself is not reset.
module fft_sched_frame_ram #(
    parameter int AW = 6,
    parameter int W  = 32
) (
    input  logic          iclk,
    input  logic          rstn,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0] r_mem [0:DEPTH-1];
    logic [W-1:0] r_rdata;

    always_ff @(posedge iclk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read register holds its value between bursts so the core inputs stay stable.
    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fft_frame_sched.sv
// Buffers one frame, then feeds the FFT core a gap-free burst; tracks frames in flight and
// frames leaving the core, flagging protocol errors.
module fft_frame_sched
    import fft_sched_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int FFT_STAGE    = FFT_STAGE_DEF,
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
    input  logic               iclk,
    input  logic               rstn,
    fft_frame_sched_if.slave   sif
);
    localparam logic [FFT_STAGE-1:0] LAST_IDX = {FFT_STAGE{1'b1}};
    localparam logic [INFL_W-1:0]    INFL_MAX = INFL_W'(MAX_INFLIGHT);

    state_t                  r_state;
    state_t                  w_next;
    logic [FFT_STAGE-1:0]    r_wr_cnt;
    logic [FFT_STAGE-1:0]    r_rd_cnt;
    logic [FFT_STAGE-1:0]    r_oe_cnt;
    logic [INFL_W-1:0]       r_inflight;
    logic                    r_s_ready;
    logic                    r_core_en;
    logic [15:0]             r_frames_out;
    logic                    r_err;
    logic                    w_acc;
    logic                    w_rd_en;
    logic                    w_burst_done;
    logic                    w_frame_done;
    logic [2*DATA_WIDTH-1:0] w_rdata;

    assign w_acc        = sif.s_valid & r_s_ready;
    assign w_burst_done = (r_state == ST_BURST) && (r_rd_cnt == LAST_IDX);
    assign w_frame_done = sif.core_oen && (r_oe_cnt == LAST_IDX);

    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_rd_en = 1'b0;
        case (r_state)
            ST_FILL:  if (w_acc && (r_wr_cnt == LAST_IDX)) w_next = ST_HOLD;
            ST_HOLD:  if (r_inflight < INFL_MAX) w_next = ST_BURST;
            ST_BURST: begin
                w_rd_en = 1'b1;
                if (r_rd_cnt == LAST_IDX) w_next = ST_FILL;
            end
            default:  w_next = ST_FILL;
        endcase
    end

    // s_ready is registered from the next state so it reads 0 during reset and the
    // scheduler reopens the cycle after the last burst address.
    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            r_s_ready <= 1'b0;
            r_core_en <= 1'b0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
        end else begin
            r_s_ready <= (w_next == ST_FILL);
            r_core_en <= w_rd_en;
            if (w_acc) r_wr_cnt <= r_wr_cnt + 1'b1;
            if (w_rd_en) r_rd_cnt <= r_rd_cnt + 1'b1;
        end
    end

    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            r_oe_cnt     <= '0;
            r_frames_out <= '0;
            r_inflight   <= '0;
            r_err        <= 1'b0;
        end else begin
            if (sif.core_oen) r_oe_cnt <= r_oe_cnt + 1'b1;
            if (w_frame_done) r_frames_out <= r_frames_out + 16'd1;
            // Burst issue and frame completion in the same cycle cancel out.
            case ({w_burst_done, w_frame_done})
                2'b10:   if (r_inflight != INFL_MAX) r_inflight <= r_inflight + 3'd1;
                2'b01:   if (r_inflight != '0) r_inflight <= r_inflight - 3'd1;
                default: r_inflight <= r_inflight;
            endcase
            if ((sif.core_oen && (r_inflight == '0)) ||
                (w_burst_done && !w_frame_done && (r_inflight == INFL_MAX))) begin
                r_err <= 1'b1;
            end
        end
    end

    fft_sched_frame_ram #(
        .AW (FFT_STAGE),
        .W  (2*DATA_WIDTH)
    ) u_ram (
        .iclk    (iclk),
        .rstn    (rstn),
        .i_we    (w_acc),
        .i_waddr (r_wr_cnt),
        .i_wdata ({sif.s_real, sif.s_imag}),
        .i_re    (w_rd_en),
        .i_raddr (r_rd_cnt),
        .o_rdata (w_rdata)
    );

    assign sif.s_ready    = r_s_ready;
    assign sif.core_en    = r_core_en;
    assign sif.core_real  = w_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
    assign sif.core_imag  = w_rdata[DATA_WIDTH-1:0];
    assign sif.m_last     = w_frame_done;
    assign sif.frames_out = r_frames_out;
    assign sif.err        = r_err;
    assign sif.dbg_state  = r_state;
    assign sif.busy       = (r_wr_cnt != '0) | (r_state != ST_FILL) | r_core_en | (r_inflight != '0);

endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed bench for fft_frame_sched with an 80-cycle delay-line model of the FFT core.
module tb_fft_frame_sched;
    import fft_sched_pkg::*;

    localparam int DW       = 16;
    localparam int N        = 64;
    localparam int CORE_DLY = 80;

    logic                iclk = 1'b0;
    logic                rstn = 1'b0;
    logic                man_oen = 1'b0;
    logic                model_on = 1'b0;
    logic [CORE_DLY-1:0] r_dly;
    int                  n_checks = 0;
    int                  n_errors = 0;
    int                  bursts = 0;
    int                  run_len = 0;
    int                  oen_seen = 0;
    logic [2*DW-1:0]     exp_q[$];

    fft_frame_sched_if #(.DW(DW)) sif();

    fft_frame_sched #(
        .DATA_WIDTH   (DW),
        .FFT_STAGE    (6),
        .MAX_INFLIGHT (2)
    ) dut (
        .iclk (iclk),
        .rstn (rstn),
        .sif  (sif)
    );

    // clock / core model
    always #5 iclk = ~iclk;

    always @(posedge iclk or negedge rstn) begin
        if (!rstn) r_dly <= '0;
        else       r_dly <= {r_dly[CORE_DLY-2:0], sif.core_en & model_on};
    end

    assign sif.core_oen = r_dly[CORE_DLY-1] | man_oen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im);
        int t;
        t = 0;
        @(negedge iclk);
        sif.s_valid = 1'b1;
        sif.s_real  = re;
        sif.s_imag  = im;
        while (!sif.s_ready && t < 500) begin
            @(negedge iclk);
            t++;
        end
        if (!sif.s_ready) begin
            chk("s_ready_timeout", 32'(sif.s_ready), 32'd1);
            sif.s_valid = 1'b0;
        end else begin
            @(posedge iclk);
            exp_q.push_back({re, im});
            #1 sif.s_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] base);
        logic [DW-1:0] v;
        for (int i = 0; i < N; i++) begin
            v = base + DW'(i);
            send(v, ~v);
        end
    endtask

    task automatic core_frame();
        for (int i = 0; i < N; i++) begin
            @(posedge iclk);
            #1 man_oen = 1'b1;
        end
        @(posedge iclk);
        #1 man_oen = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int t;
        t = 0;
        while (sif.frames_out != 16'(target) && t < budget) begin
            @(negedge iclk);
            t++;
        end
        chk("frames_out", 32'(sif.frames_out), 32'(target));
    endtask

    task automatic do_reset();
        @(negedge iclk);
        rstn    = 1'b0;
        man_oen = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_s_ready", 32'(sif.s_ready), 32'd0);
        chk("rst_core_en", 32'(sif.core_en), 32'd0);
        chk("rst_core_data", {sif.core_real, sif.core_imag}, 32'd0);
        chk("rst_m_last", 32'(sif.m_last), 32'd0);
        chk("rst_busy", 32'(sif.busy), 32'd0);
        chk("rst_frames_out", 32'(sif.frames_out), 32'd0);
        chk("rst_err", 32'(sif.err), 32'd0);
        chk("rst_state", 32'(sif.dbg_state), 32'(ST_FILL));
        repeat (2) @(negedge iclk);
        rstn = 1'b1;
    endtask

    // scoreboard monitor
    always @(negedge iclk) begin
        if (!rstn) begin
            run_len  = 0;
            oen_seen = 0;
        end else begin
            if (sif.core_en) begin
                run_len++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL core_data: got %0h with no sample expected", {sif.core_real, sif.core_imag});
                end else begin
                    chk("core_data", {sif.core_real, sif.core_imag}, exp_q.pop_front());
                end
            end else if (run_len != 0) begin
                chk("burst_len", 32'(run_len), 32'(N));
                bursts++;
                run_len = 0;
            end
            if (sif.core_oen) begin
                oen_seen++;
                chk("m_last", 32'(sif.m_last), 32'((oen_seen % N) == 0));
            end
        end
    end

    initial begin
        int lat;
        int b0;
        sif.s_valid = 1'b0;
        sif.s_real  = '0;
        sif.s_imag  = '0;

        // ramp frame, continuous valid, latency to first core_en
        do_reset();
        model_on = 1'b1;
        for (int i = 0; i < N; i++) send(DW'(i), DW'(16'h8000 + i));
        lat = 0;
        while (!sif.core_en && lat < 10) begin
            @(negedge iclk);
            lat++;
        end
        chk("latency", 32'(lat), 32'd3);
        wait_frames(1, 400);

        // bursty input with gaps
        for (int i = 0; i < N; i++) begin
            send(DW'(16'h0100 + 3*i), DW'(16'hA000 ^ i));
            repeat ($urandom_range(0, 1)) @(negedge iclk);
        end
        wait_frames(2, 400);
        chk("queue_empty_2", 32'(exp_q.size()), 32'd0);

        // stalled core: third frame held off until the first frame leaves
        do_reset();
        model_on = 1'b0;
        b0 = bursts;
        send_frame(16'h1000);
        send_frame(16'h2000);
        send_frame(16'h3000);
        repeat (100) @(negedge iclk);
        chk("hold_state", 32'(sif.dbg_state), 32'(ST_HOLD));
        chk("hold_s_ready", 32'(sif.s_ready), 32'd0);
        chk("hold_bursts", 32'(bursts - b0), 32'd2);
        chk("hold_err", 32'(sif.err), 32'd0);
        core_frame();
        @(negedge iclk);
        chk("release_hold", 32'(sif.dbg_state), 32'(ST_HOLD));
        @(negedge iclk);
        chk("release_burst", 32'(sif.dbg_state), 32'(ST_BURST));
        repeat (80) @(negedge iclk);
        core_frame();
        core_frame();
        @(negedge iclk);
        chk("stall_frames_out", 32'(sif.frames_out), 32'd3);
        chk("stall_busy", 32'(sif.busy), 32'd0);
        chk("stall_err", 32'(sif.err), 32'd0);
        chk("queue_empty_3", 32'(exp_q.size()), 32'd0);

        // four frames through the core model
        do_reset();
        model_on = 1'b1;
        b0 = bursts;
        for (int f = 0; f < 4; f++) send_frame(DW'(16'h4000 + f*16'h0400));
        wait_frames(4, 600);
        chk("four_busy", 32'(sif.busy), 32'd0);
        chk("four_bursts", 32'(bursts - b0), 32'd4);
        chk("queue_empty_4", 32'(exp_q.size()), 32'd0);

        // stray oen sets sticky err
        do_reset();
        model_on = 1'b0;
        @(posedge iclk);
        #1 man_oen = 1'b1;
        @(negedge iclk);
        chk("err_before", 32'(sif.err), 32'd0);
        @(posedge iclk);
        #1 man_oen = 1'b0;
        @(negedge iclk);
        chk("err_set", 32'(sif.err), 32'd1);
        repeat (20) @(negedge iclk);
        chk("err_sticky", 32'(sif.err), 32'd1);
        rstn = 1'b0;
        #1 chk("err_cleared", 32'(sif.err), 32'd0);

        // reset in the middle of a burst
        do_reset();
        model_on = 1'b0;
        send_frame(16'h5000);
        lat = 0;
        while (!sif.core_en && lat < 10) begin
            @(negedge iclk);
            lat++;
        end
        chk("mid_burst_seen", 32'(sif.core_en), 32'd1);
        repeat (19) @(negedge iclk);
        #1 rstn = 1'b0;
        #1;
        chk("mid_rst_core_en", 32'(sif.core_en), 32'd0);
        chk("mid_rst_s_ready", 32'(sif.s_ready), 32'd0);
        chk("mid_rst_busy", 32'(sif.busy), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge iclk);
        rstn = 1'b1;
        @(negedge iclk);
        chk("post_rst_s_ready", 32'(sif.s_ready), 32'd1);
        chk("post_rst_frames", 32'(sif.frames_out), 32'd0);
        chk("post_rst_state", 32'(sif.dbg_state), 32'(ST_FILL));
        model_on = 1'b1;
        send_frame(16'h6000);
        wait_frames(1, 400);
        chk("queue_empty_6", 32'(exp_q.size()), 32'd0);
        chk("post_rst_err", 32'(sif.err), 32'd0);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
